// File: rtl/ex_stage_mem_reg_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forward selects
// and the multiply sequencer state encoding.
package ex_stage_mem_reg_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SLL   = 4'd3;
  localparam logic [3:0] ALU_SRL   = 4'd4;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MULTU = 4'd8;
  localparam logic [3:0] ALU_MFHI  = 4'd9;
  localparam logic [3:0] ALU_MFLO  = 4'd10;

  localparam logic [1:0] FWD_IDEX  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_WB    = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/ex_stage_mem_reg_multu.sv
// Iterative unsigned multiplier: one shift-add step per cycle, HI/LO result
// registers, and the stall/done handshake the execute stage uses to freeze
// the front of the pipeline while a MULTU is in flight.
module multu_seq
  import ex_stage_mem_reg_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] mcand_in,
  input  logic [W-1:0] mplier_in,
  output logic         stall,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   mcand_p0;
  logic [2*W-1:0]   acc_p0;
  logic [W-1:0]     mplier_p0;
  logic [2*W-1:0]   acc_sum;
  logic             load, step, finish;

  // Partial product for the current multiplier bit; also the final product
  // on the last iteration, so HI/LO load without waiting an extra cycle.
  assign acc_sum = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

  // Next-state and handshake decode. A start is ignored while reset is held
  // so stall stays low for the whole reset interval.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush && !rst) begin
          stall   = 1'b1;
          load    = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        stall = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, iteration counter and architectural HI/LO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (load)      cnt_q <= '0;
      else if (step) cnt_q <= cnt_q + CNT_W'(1);
      if (finish)    {hi, lo} <= acc_sum;
    end
  end

  // Shift-add datapath: multiplicand walks left, multiplier walks right.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand_p0  <= {{W{1'b0}}, mcand_in};
      mplier_p0 <= mplier_in;
      acc_p0    <= '0;
    end else if (step) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      acc_p0    <= acc_sum;
    end
  end

endmodule

// File: rtl/ex_stage_mem_reg.sv
// Execute stage: operand forwarding, ALU-B source select, ALU, the iterative
// MULTU unit, and the EX/MEM pipeline register feeding the memory stage.
module ex_stage_mem_reg
  import ex_stage_mem_reg_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] id_ex_alu_pa,
  input  logic [W-1:0] id_ex_alu_pb,
  input  logic [W-1:0] id_ex_sext_imm,
  input  logic [4:0]   id_ex_shamt,
  input  logic [4:0]   id_ex_rf_wa,
  input  logic [3:0]   id_ex_alu_ctrl,
  input  logic         id_ex_alu_src,
  input  logic         id_ex_we_reg,
  input  logic         id_ex_dm2reg,
  input  logic         id_ex_we_dm,
  input  logic [1:0]   fwd_a,
  input  logic [1:0]   fwd_b,
  input  logic [W-1:0] wb_data,
  input  logic         flush,
  output logic         stall,
  output logic         zero,
  output logic [W-1:0] ex_mem_alu_out,
  output logic [W-1:0] ex_mem_wd_dm,
  output logic [4:0]   ex_mem_rf_wa,
  output logic         ex_mem_we_reg,
  output logic         ex_mem_dm2reg,
  output logic         ex_mem_we_dm,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  logic [W-1:0]        op_a, op_bf, op_b, alu_result;
  logic signed [W-1:0] op_a_s, op_b_s;
  logic                mul_done, bubble;

  // Forwarding muxes; select 3 falls back to the ID/EX operand.
  always_comb begin
    case (fwd_a)
      FWD_EXMEM: op_a = ex_mem_alu_out;
      FWD_WB:    op_a = wb_data;
      default:   op_a = id_ex_alu_pa;
    endcase
    case (fwd_b)
      FWD_EXMEM: op_bf = ex_mem_alu_out;
      FWD_WB:    op_bf = wb_data;
      default:   op_bf = id_ex_alu_pb;
    endcase
  end

  assign op_b   = id_ex_alu_src ? id_ex_sext_imm : op_bf;
  assign op_a_s = op_a;
  assign op_b_s = op_b;

  // ALU; shifts take the forwarded register operand, never the immediate.
  always_comb begin
    alu_result = '0;
    case (id_ex_alu_ctrl)
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SLL:  alu_result = op_bf << id_ex_shamt;
      ALU_SRL:  alu_result = op_bf >> id_ex_shamt;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLT:  alu_result = (op_a_s < op_b_s) ? W'(1) : '0;
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  multu_seq #(
    .W          (W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_multu (
    .clk       (clk),
    .rst       (rst),
    .start     (id_ex_alu_ctrl == ALU_MULTU),
    .flush     (flush),
    .mcand_in  (op_a),
    .mplier_in (op_bf),
    .stall     (stall),
    .done      (mul_done),
    .hi        (hi),
    .lo        (lo)
  );

  // A squashed, stalled or retiring-MULTU instruction enters MEM as a bubble.
  assign bubble = flush | stall | mul_done;

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      ex_mem_alu_out <= '0;
      ex_mem_wd_dm   <= '0;
      ex_mem_rf_wa   <= '0;
      ex_mem_we_reg  <= 1'b0;
      ex_mem_dm2reg  <= 1'b0;
      ex_mem_we_dm   <= 1'b0;
    end else begin
      ex_mem_alu_out <= alu_result;
      ex_mem_wd_dm   <= op_bf;
      ex_mem_rf_wa   <= id_ex_rf_wa;
      ex_mem_we_reg  <= id_ex_we_reg;
      ex_mem_dm2reg  <= id_ex_dm2reg;
      ex_mem_we_dm   <= id_ex_we_dm;
    end
  end

endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// Bench for the execute stage: directed vector table, MULTU corner
// sequences, and randomized ALU traffic against an arithmetic model.
module tb_ex_stage_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pa, pb, imm, wb;
  logic [4:0]  sh, wa;
  logic [3:0]  ctrl;
  logic        src, we, dm, wdm, flush;
  logic [1:0]  fa, fb;
  logic        stall, zero;
  logic [31:0] ex_mem_alu_out, ex_mem_wd_dm, hi, lo;
  logic [4:0]  ex_mem_rf_wa;
  logic        ex_mem_we_reg, ex_mem_dm2reg, ex_mem_we_dm;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi, m_lo, m_prev;

  ex_stage_mem_reg dut (
    .clk(clk), .rst(rst),
    .id_ex_alu_pa(pa), .id_ex_alu_pb(pb), .id_ex_sext_imm(imm),
    .id_ex_shamt(sh), .id_ex_rf_wa(wa), .id_ex_alu_ctrl(ctrl),
    .id_ex_alu_src(src), .id_ex_we_reg(we), .id_ex_dm2reg(dm),
    .id_ex_we_dm(wdm), .fwd_a(fa), .fwd_b(fb), .wb_data(wb),
    .flush(flush), .stall(stall), .zero(zero),
    .ex_mem_alu_out(ex_mem_alu_out), .ex_mem_wd_dm(ex_mem_wd_dm),
    .ex_mem_rf_wa(ex_mem_rf_wa), .ex_mem_we_reg(ex_mem_we_reg),
    .ex_mem_dm2reg(ex_mem_dm2reg), .ex_mem_we_dm(ex_mem_we_dm),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] pa, pb, imm;
    logic [4:0]  sh;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] wb;
    logic [4:0]  wa;
    logic        we, dm, wdm;
    logic [31:0] e_out, e_wd;
    logic        e_zero;
  } vec_t;

  vec_t tab[12];
  int   ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 10, 11, 15};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, b, im,
                       input logic [4:0] s, input logic sr, input logic [1:0] xa, xb,
                       input logic [31:0] w, input logic [4:0] d,
                       input logic e, m, md);
    ctrl = c; pa = a; pb = b; imm = im; sh = s; src = sr;
    fa = xa; fb = xb; wb = w; wa = d; we = e; dm = m; wdm = md;
  endtask

  function automatic logic [71:0] regs();
    return {ex_mem_alu_out, ex_mem_wd_dm, ex_mem_rf_wa, ex_mem_we_reg, ex_mem_dm2reg, ex_mem_we_dm};
  endfunction

  // Reference ALU written from the op definitions with plain arithmetic.
  function automatic logic [31:0] model_alu(input int op, input logic [31:0] a, b, bf,
                                            input logic [4:0] s);
    longint unsigned t;
    int sa, sb;
    sa = a; sb = b;
    case (op)
      0: return a & b;
      1: return a | b;
      2: begin t = longint'(a) + longint'(b); return t[31:0]; end
      3: begin t = longint'(bf) * (64'd1 << s); return t[31:0]; end
      4: return bf / (32'd1 << s);
      6: begin t = longint'(a) + (64'h1_0000_0000 - longint'(b)); return t[31:0]; end
      7: return (sa < sb) ? 32'd1 : 32'd0;
      9: return m_hi;
      10: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one MULTU (entered just after a rising edge) and follow it through
  // DONE; returns just after the edge that retires it.
  task automatic run_mul(input string nm, input logic [31:0] a, b);
    longint unsigned p;
    int n;
    logic seen_we;
    logic finished;
    p = longint'(a) * longint'(b);
    drive(4'd8, a, b, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    n = 0; seen_we = 1'b0; finished = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 0 && (ex_mem_we_reg || ex_mem_we_dm)) seen_we = 1'b1;
      if (!stall) begin finished = 1'b1; break; end
      n++;
      @(posedge clk); #1;
    end
    chk({nm, "_finished"}, finished, 1'b1);
    chk({nm, "_stall_cycles"}, n, 33);
    chk({nm, "_no_write"}, seen_we, 1'b0);
    chk({nm, "_hilo"}, {hi, lo}, p);
    m_hi = p[63:32]; m_lo = p[31:0];
    @(posedge clk); #1;
    chk({nm, "_done_bubble"}, regs(), 72'h0);
  endtask

  initial begin
    logic [31:0] a, bf, b, r;
    logic        fl;
    int          op;

    rst = 1'b1; flush = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {regs(), hi, lo, stall}, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    //             ctrl pa            pb            imm           sh  src fa fb wb     wa  we dm wdm out           wd            zero
    tab[0]  = '{4'd2, 32'd5,        32'h11,       32'hFFFFFFFD, 5'd0, 1, 0, 0, 32'h0,  5'd8, 1, 0, 0, 32'd2,        32'h11,       0};
    tab[1]  = '{4'd7, 32'hFFFFFFFF, 32'd1,        32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd3, 1, 0, 0, 32'd1,        32'd1,        0};
    tab[2]  = '{4'd4, 32'h0,        32'h80000000, 32'h0,        5'd31,0, 0, 0, 32'h0,  5'd4, 1, 0, 0, 32'd1,        32'h80000000, 0};
    tab[3]  = '{4'd6, 32'd7,        32'd7,        32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd5, 1, 0, 0, 32'd0,        32'd7,        1};
    tab[4]  = '{4'd2, 32'h10,       32'h0,        32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd6, 1, 0, 0, 32'h10,       32'h0,        0};
    tab[5]  = '{4'd2, 32'hDEAD,     32'hBEEF,     32'h0,        5'd0, 0, 1, 2, 32'h20, 5'd0, 0, 0, 1, 32'h30,       32'h20,       0};
    tab[6]  = '{4'd0, 32'hF0F0,     32'hFF00,     32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd7, 1, 0, 0, 32'hF000,     32'hFF00,     0};
    tab[7]  = '{4'd1, 32'hF0F0,     32'hFF00,     32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd7, 1, 1, 0, 32'hFFF0,     32'hFF00,     0};
    tab[8]  = '{4'd3, 32'h0,        32'd1,        32'hFFFF,     5'd4, 1, 0, 0, 32'h0,  5'd2, 1, 0, 0, 32'h10,       32'd1,        0};
    tab[9]  = '{4'd5, 32'd3,        32'd4,        32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd1, 1, 0, 0, 32'd0,        32'd4,        1};
    tab[10] = '{4'd2, 32'd1,        32'd2,        32'h0,        5'd0, 0, 3, 3, 32'h99, 5'd9, 1, 0, 0, 32'd3,        32'd2,        0};
    tab[11] = '{4'd6, 32'd0,        32'd1,        32'h0,        5'd0, 0, 0, 0, 32'h0,  5'd31,1, 0, 0, 32'hFFFFFFFF, 32'd1,        0};

    for (int i = 0; i < 12; i++) begin
      drive(tab[i].ctrl, tab[i].pa, tab[i].pb, tab[i].imm, tab[i].sh, tab[i].src,
            tab[i].fa, tab[i].fb, tab[i].wb, tab[i].wa, tab[i].we, tab[i].dm, tab[i].wdm);
      @(negedge clk);
      chk($sformatf("vec%0d_zero_stall", i), {zero, stall}, {tab[i].e_zero, 1'b0});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_exmem", i), regs(),
          {tab[i].e_out, tab[i].e_wd, tab[i].wa, tab[i].we, tab[i].dm, tab[i].wdm});
    end

    // Full-width multiply, then MFLO straight after it.
    run_mul("mul_max", 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_max_hi_const", hi, 32'hFFFFFFFE);
    drive(4'd10, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("mflo_after_mul", {ex_mem_alu_out, ex_mem_we_reg, ex_mem_rf_wa}, {32'd1, 1'b1, 5'd10});

    // Flush during MUL cycle 10 aborts without touching HI/LO.
    drive(4'd8, 32'd3, 32'd4, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_same_cycle", stall, 1'b1);
    @(posedge clk); #1;
    chk("flush_bubble", regs(), 72'h0);
    flush = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_stall_low", stall, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    chk("flush_hilo_kept", {hi, lo}, {m_hi, m_lo});

    // Randomized single-cycle traffic against the model.
    m_prev = 32'h0;
    for (int i = 0; i < 200; i++) begin
      op = ops[$urandom_range(0, 11)];
      drive(op[3:0], $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      fl = ($urandom_range(0, 7) == 0);
      flush = fl;
      a  = (fa == 2'd1) ? m_prev : (fa == 2'd2) ? wb : pa;
      bf = (fb == 2'd1) ? m_prev : (fb == 2'd2) ? wb : pb;
      b  = src ? imm : bf;
      r  = model_alu(op, a, b, bf, sh);
      @(negedge clk);
      chk($sformatf("rnd%0d_op%0d_zero_stall", i, op), {zero, stall}, {(r == 32'h0), 1'b0});
      @(posedge clk); #1;
      if (fl) begin
        chk($sformatf("rnd%0d_flush", i), regs(), 72'h0);
        m_prev = 32'h0;
      end else begin
        chk($sformatf("rnd%0d_op%0d", i, op), regs(), {r, bf, wa, we, dm, wdm});
        m_prev = r;
      end
    end
    flush = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    drive(4'd8, 32'd3, 32'd5, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_mul", {regs(), hi, lo, stall}, '0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_mul("mul_6x7", 32'd6, 32'd7);
    chk("mul_6x7_lo_const", {hi, lo}, {32'd0, 32'd42});
    run_mul("mul_b2b", 32'h12345678, 32'h9ABCDEF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_mem_reg.md
Name: ex_stage_mem_reg

Overview:
- Execute stage plus EX/MEM pipeline register.
- Consumes the ID/EX register outputs, applies forwarding and the ALU-B source mux, and computes the ALU result.
- Contains a 32-cycle iterative MULTU unit with HI/LO registers and stalls the upstream stages while that unit is busy.
- Registers the result and memory/writeback controls for the MEM stage.

Parameters:
- W, 32, datapath width.
- MUL_CYCLES, 32, shift-add iterations (equals W).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_ex_alu_pa  in  32  operand A from ID/EX
- id_ex_alu_pb  in  32  operand B (rd2) from ID/EX
- id_ex_sext_imm  in  32  sign-extended immediate
- id_ex_shamt  in  5  shift amount
- id_ex_rf_wa  in  5  resolved destination register
- id_ex_alu_ctrl  in  4  ALU op
- id_ex_alu_src  in  1  1 = B is immediate
- id_ex_we_reg / id_ex_dm2reg / id_ex_we_dm  in  1 each  controls
- fwd_a, fwd_b  in  2 each  0 = ID/EX value, 1 = ex_mem_alu_out, 2 = wb_data, 3 = ID/EX value
- wb_data  in  32  writeback-stage data
- flush  in  1  squash the current EX instruction
- stall  out  1  hold PC, IF/ID and ID/EX
- zero  out  1  combinational, ALU result == 0
- ex_mem_alu_out  out  32  registered result
- ex_mem_wd_dm  out  32  registered forwarded B (store data)
- ex_mem_rf_wa  out  5
- ex_mem_we_reg, ex_mem_dm2reg, ex_mem_we_dm  out  1 each
- hi, lo  out  32 each  multiply result registers

Behaviour:
- Reset: every output register, hi, lo, the FSM state and the counter go to 0; FSM = IDLE. stall is 0 after reset because the FSM is in IDLE and no MULTU is decoded.
- Operand selection: a = fwd_a mux; bf = fwd_b mux; b = alu_src ? sext_imm : bf.
- alu_ctrl encoding:
  - 0 AND, 1 OR, 2 ADD (wraps mod 2^32, no overflow trap)
  - 3 SLL: bf << shamt
  - 4 SRL: bf >> shamt (logical)
  - 6 SUB
  - 7 SLT: signed, result 1/0
  - 8 MULTU
  - 9 MFHI: result = hi
  - 10 MFLO: result = lo
  - All other codes give result 0; register write is still honoured.
- Shifts use bf, not the immediate.
- EX/MEM register, normal case: 1-cycle latency; loads the result, bf, rf_wa and controls on every clk.
- EX/MEM register, bubble case: the register loads a bubble (we_reg = we_dm = dm2reg = 0, data and rf_wa = 0) when any of these hold:
  - flush = 1
  - stall = 1
  - the FSM is in DONE
- Multiply FSM:
  - IDLE: when alu_ctrl == 8 and flush = 0, stall = 1 in this cycle. Capture the multiplicand from a and the multiplier from bf, clear the 64-bit accumulator and count, then go to MUL.
  - MUL: stall = 1. Each cycle performs one shift-add step and increments count. When count == MUL_CYCLES-1, write {hi, lo} = product and go to DONE.
  - DONE: stall = 0, so upstream advances. The MULTU retires as a bubble. Unconditionally return to IDLE. alu_ctrl is ignored in DONE.
- MULTU occupancy is MUL_CYCLES+2 cycles, with stall high for MUL_CYCLES+1 of them. hi/lo are visible from the DONE cycle onward.
- Back-to-back MULTU: the second MULTU is seen in IDLE on the cycle after DONE and starts normally.
- MFHI/MFLO immediately after MULTU reads the new hi/lo. No extra interlock is needed.
- flush in MUL aborts: go to IDLE, hi/lo unchanged, stall drops in the next cycle.
- flush in IDLE together with MULTU: no start.
- rst mid-multiply: immediate abort; all state is zeroed.
- Forwarding selects 1/2 are used as given; there is no internal hazard check.

Decomposition:
- Shared package holds:
  - alu_ctrl constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SUB, ALU_SLT, ALU_MULTU, ALU_MFHI, ALU_MFLO
  - forward-select constants: FWD_IDEX, FWD_EXMEM, FWD_WB
  - FSM state encoding: IDLE, MUL, DONE
- One natural sub-module: multu_seq, holding the FSM, counter, accumulator and hi/lo with start/flush/stall/done ports.
- The ALU, muxes and EX/MEM register stay at top level.

Test Plan:
- ADD a=5, imm=0xFFFFFFFD, alu_src=1, we_reg=1, rf_wa=8 -> next cycle ex_mem_alu_out=2, ex_mem_we_reg=1, ex_mem_rf_wa=8, zero was 0.
- SLT a=0xFFFFFFFF, b=1 -> 1. SRL bf=0x80000000, shamt=31 -> 1. SUB 7-7 -> zero=1.
- Forwarding: ex_mem_alu_out=0x10, wb_data=0x20, fwd_a=1, fwd_b=2, ADD -> 0x30. The store (we_dm=1) has ex_mem_wd_dm=0x20.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 33 cycles and low in DONE; hi=0xFFFFFFFE, lo=0x00000001. The following MFLO gives 1; no we_reg during MULTU.
- MULTU 3x4 with flush asserted at MUL cycle 10 -> IDLE next cycle, stall low, hi/lo keep their prior values, EX/MEM is a bubble.
- rst pulsed at MUL cycle 5 (async, mid-clock) -> all outputs 0 immediately. After release, MULTU 6x7 completes with lo=42, hi=0.
